// File: rtl/comp_bist.sv
// Self-test driver/checker for an unsigned a > b comparator: walks a up and b down from seeds.
// One vector per SETTLE cycles, done_o N*SETTLE+1 cycles after start; start_i is ignored unless idle.
module comp_bist #(
  parameter int WIDTH  = 8,
  parameter int SETTLE = 1,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             aresetn,
  input  logic             start_i,
  input  logic [WIDTH-1:0] seed_a_i,
  input  logic [WIDTH-1:0] seed_b_i,
  input  logic [CNT_W-1:0] num_vec_i,
  output logic [WIDTH-1:0] a_o,
  output logic [WIDTH-1:0] b_o,
  input  logic             c_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             pass_o,
  output logic [CNT_W-1:0] err_cnt_o,
  output logic             first_err_vld_o,
  output logic [WIDTH-1:0] first_err_a_o,
  output logic [WIDTH-1:0] first_err_b_o
);

  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] fa_q, fa_d, fb_q, fb_d;
  logic [CNT_W-1:0] n_q, n_d, vec_q, vec_d, err_q, err_d;
  logic [SW-1:0]    set_q, set_d;
  logic             pass_q, pass_d, fv_q, fv_d;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    fa_d    = fa_q;
    fb_d    = fb_q;
    n_d     = n_q;
    vec_d   = vec_q;
    err_d   = err_q;
    set_d   = set_q;
    pass_d  = pass_q;
    fv_d    = fv_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          a_d    = seed_a_i;
          b_d    = seed_b_i;
          n_d    = num_vec_i;
          vec_d  = '0;
          set_d  = '0;
          err_d  = '0;
          fv_d   = 1'b0;
          fa_d   = '0;
          fb_d   = '0;
          pass_d = 1'b0;
          if (num_vec_i == '0) begin
            pass_d  = 1'b1;
            state_d = DONE;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (set_q != SW'(SETTLE - 1)) begin
          set_d = set_q + SW'(1);
        end else begin
          // Sample edge: c_i has had SETTLE cycles to respond to the current a/b.
          set_d = '0;
          if (c_i != (a_q > b_q)) begin
            if (err_q != '1) err_d = err_q + CNT_W'(1);
            if (!fv_q) begin
              fv_d = 1'b1;
              fa_d = a_q;
              fb_d = b_q;
            end
          end
          if (vec_q == n_q - CNT_W'(1)) begin
            pass_d  = (err_d == '0);
            state_d = DONE;
          end else begin
            vec_d = vec_q + CNT_W'(1);
            a_d   = a_q + WIDTH'(1);
            b_d   = b_q - WIDTH'(1);
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      fa_q    <= '0;
      fb_q    <= '0;
      n_q     <= '0;
      vec_q   <= '0;
      err_q   <= '0;
      set_q   <= '0;
      pass_q  <= 1'b0;
      fv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      fa_q    <= fa_d;
      fb_q    <= fb_d;
      n_q     <= n_d;
      vec_q   <= vec_d;
      err_q   <= err_d;
      set_q   <= set_d;
      pass_q  <= pass_d;
      fv_q    <= fv_d;
    end
  end

  assign a_o             = a_q;
  assign b_o             = b_q;
  assign busy_o          = (state_q == RUN);
  assign done_o          = (state_q == DONE);
  assign pass_o          = pass_q;
  assign err_cnt_o       = err_q;
  assign first_err_vld_o = fv_q;
  assign first_err_a_o   = fa_q;
  assign first_err_b_o   = fb_q;

endmodule

// File: tb/tb_comp_bist.sv
// Bench for comp_bist: SETTLE=1 and SETTLE=3 instances share stimulus, each driven by its own comparator model.
module tb_comp_bist;
  localparam int W  = 8;
  localparam int CW = 16;
  localparam int NI = 2;

  logic          clk = 1'b0;
  logic          aresetn = 1'b0;
  logic          start_i = 1'b0;
  logic [W-1:0]  seed_a = '0, seed_b = '0;
  logic [CW-1:0] num = '0;

  logic [W-1:0]  a_w[NI], b_w[NI], fa_w[NI], fb_w[NI];
  logic          c_w[NI], busy_w[NI], done_w[NI], pass_w[NI], fv_w[NI];
  logic [CW-1:0] err_w[NI];

  int n_chk = 0;
  int n_fail = 0;
  int mode = 0;   // 0 ideal, 1 a>=b, 2 stuck-at-0, 3 ideal delayed 2 cycles
  bit d1[NI], d2[NI];

  always #5 clk = ~clk;

  comp_bist #(.WIDTH(W), .SETTLE(1), .CNT_W(CW)) u1 (
    .clk(clk), .aresetn(aresetn), .start_i(start_i), .seed_a_i(seed_a), .seed_b_i(seed_b),
    .num_vec_i(num), .a_o(a_w[0]), .b_o(b_w[0]), .c_i(c_w[0]), .busy_o(busy_w[0]),
    .done_o(done_w[0]), .pass_o(pass_w[0]), .err_cnt_o(err_w[0]), .first_err_vld_o(fv_w[0]),
    .first_err_a_o(fa_w[0]), .first_err_b_o(fb_w[0]));

  comp_bist #(.WIDTH(W), .SETTLE(3), .CNT_W(CW)) u3 (
    .clk(clk), .aresetn(aresetn), .start_i(start_i), .seed_a_i(seed_a), .seed_b_i(seed_b),
    .num_vec_i(num), .a_o(a_w[1]), .b_o(b_w[1]), .c_i(c_w[1]), .busy_o(busy_w[1]),
    .done_o(done_w[1]), .pass_o(pass_w[1]), .err_cnt_o(err_w[1]), .first_err_vld_o(fv_w[1]),
    .first_err_a_o(fa_w[1]), .first_err_b_o(fb_w[1]));

  always @(posedge clk) begin
    for (int i = 0; i < NI; i++) begin
      d1[i] <= (a_w[i] > b_w[i]);
      d2[i] <= d1[i];
    end
  end

  always @* begin
    for (int i = 0; i < NI; i++) begin
      case (mode)
        1:       c_w[i] = (a_w[i] >= b_w[i]);
        2:       c_w[i] = 1'b0;
        3:       c_w[i] = d2[i];
        default: c_w[i] = (a_w[i] > b_w[i]);
      endcase
    end
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Model: position in a run is the edge count j since the start edge; vector k = j / SETTLE.
  bit           m_run[NI], m_pass[NI], m_fv[NI];
  int           m_j[NI], m_n[NI], m_k[NI], m_err[NI];
  logic [W-1:0] m_sa[NI], m_sb[NI], m_fa[NI], m_fb[NI];

  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      int s, tot;
      bit e_busy, e_done, expc;
      logic [W-1:0] ea, eb;
      s = (i == 0) ? 1 : 3;
      tot = m_n[i] * s;
      if (!aresetn) begin
        m_run[i] = 0; m_pass[i] = 0; m_fv[i] = 0; m_j[i] = 0; m_n[i] = 0; m_k[i] = 0;
        m_err[i] = 0; m_sa[i] = '0; m_sb[i] = '0; m_fa[i] = '0; m_fb[i] = '0;
      end else begin
        if (m_run[i]) begin
          m_k[i] = m_j[i] / s;
          if (m_k[i] > m_n[i] - 1) m_k[i] = m_n[i] - 1;
          if (m_k[i] < 0) m_k[i] = 0;
        end
        ea = m_sa[i] + W'(m_k[i]);
        eb = m_sb[i] - W'(m_k[i]);
        e_busy = m_run[i] && (m_j[i] < tot);
        e_done = m_run[i] && (m_j[i] == tot);
        chk($sformatf("u%0d_a", i), a_w[i], ea);
        chk($sformatf("u%0d_b", i), b_w[i], eb);
        chk($sformatf("u%0d_busy", i), busy_w[i], e_busy);
        chk($sformatf("u%0d_done", i), done_w[i], e_done);
        chk($sformatf("u%0d_pass", i), pass_w[i], m_pass[i]);
        chk($sformatf("u%0d_err", i), err_w[i], m_err[i]);
        chk($sformatf("u%0d_fv", i), fv_w[i], m_fv[i]);
        chk($sformatf("u%0d_fa", i), fa_w[i], m_fa[i]);
        chk($sformatf("u%0d_fb", i), fb_w[i], m_fb[i]);
        if (m_run[i]) begin
          if (m_j[i] < tot) begin
            if ((m_j[i] + 1) % s == 0) begin
              expc = (ea > eb);
              if (c_w[i] !== expc) begin
                if (m_err[i] < 65535) m_err[i]++;
                if (!m_fv[i]) begin
                  m_fv[i] = 1; m_fa[i] = ea; m_fb[i] = eb;
                end
              end
              if (m_j[i] + 1 == tot) m_pass[i] = (m_err[i] == 0);
            end
            m_j[i]++;
          end else begin
            m_run[i] = 0;
          end
        end else if (start_i) begin
          m_run[i] = 1; m_j[i] = 0; m_n[i] = int'(num); m_k[i] = 0;
          m_sa[i] = seed_a; m_sb[i] = seed_b; m_err[i] = 0;
          m_fv[i] = 0; m_fa[i] = '0; m_fb[i] = '0; m_pass[i] = (num == '0);
        end
      end
    end
  end

  task automatic zero_chk(input string tag);
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("%s_u%0d_a", tag, i), a_w[i], 0);
      chk($sformatf("%s_u%0d_b", tag, i), b_w[i], 0);
      chk($sformatf("%s_u%0d_busy", tag, i), busy_w[i], 0);
      chk($sformatf("%s_u%0d_done", tag, i), done_w[i], 0);
      chk($sformatf("%s_u%0d_pass", tag, i), pass_w[i], 0);
      chk($sformatf("%s_u%0d_err", tag, i), err_w[i], 0);
      chk($sformatf("%s_u%0d_fv", tag, i), fv_w[i], 0);
      chk($sformatf("%s_u%0d_fa", tag, i), fa_w[i], 0);
      chk($sformatf("%s_u%0d_fb", tag, i), fb_w[i], 0);
    end
  endtask

  // Returns cycles from the start edge until done_o is seen (start edge counts as cycle 1), -1 on timeout.
  task automatic run(input logic [W-1:0] sa, input logic [W-1:0] sb, input int n, input bit pulse,
                     output int cyc1, output int cyc3);
    @(posedge clk); #2;
    seed_a = sa; seed_b = sb; num = CW'(n); start_i = 1'b1;
    @(posedge clk); #2;
    start_i = 1'b0;
    cyc1 = -1;
    cyc3 = -1;
    for (int c = 1; c <= 300 && (cyc1 < 0 || cyc3 < 0); c++) begin
      if (done_w[0] && cyc1 < 0) cyc1 = c;
      if (done_w[1] && cyc3 < 0) cyc3 = c;
      start_i = pulse && (c == 4);
      @(posedge clk); #2;
    end
    start_i = 1'b0;
  endtask

  initial begin
    int c1, c3;
    bit saw;
    repeat (3) @(posedge clk);
    #2;
    zero_chk("rst");
    aresetn = 1'b1;

    mode = 0;
    run(8'd10, 8'd15, 8, 1'b1, c1, c3);
    chk("t1_cyc1", c1, 9);
    chk("t1_cyc3", c3, 25);
    chk("t1_pass", pass_w[0], 1);
    chk("t1_err", err_w[0], 0);
    chk("t1_fv", fv_w[0], 0);
    chk("t1_a_end", a_w[0], 17);
    chk("t1_b_end", b_w[0], 8);

    mode = 1;
    run(8'd10, 8'd20, 16, 1'b0, c1, c3);
    chk("t2_cyc1", c1, 17);
    chk("t2_err", err_w[0], 1);
    chk("t2_fa", fa_w[0], 15);
    chk("t2_fb", fb_w[0], 15);
    chk("t2_pass", pass_w[0], 0);
    chk("t2_err_u3", err_w[1], 1);

    mode = 2;
    run(8'd20, 8'd15, 4, 1'b0, c1, c3);
    chk("t3_err", err_w[0], 4);
    chk("t3_fa", fa_w[0], 20);
    chk("t3_fb", fb_w[0], 15);
    chk("t3_pass", pass_w[0], 0);

    mode = 0;
    run(8'hFE, 8'h01, 4, 1'b0, c1, c3);
    chk("t4_pass", pass_w[0], 1);
    chk("t4_a_end", a_w[0], 8'h01);
    chk("t4_b_end", b_w[0], 8'hFE);

    run(8'h33, 8'h44, 0, 1'b0, c1, c3);
    chk("t5_cyc1", c1, 1);
    chk("t5_cyc3", c3, 1);
    chk("t5_pass", pass_w[0], 1);
    chk("t5_err", err_w[0], 0);
    chk("t5_a", a_w[0], 8'h33);
    chk("t5_b", b_w[0], 8'h44);

    @(posedge clk); #2;
    seed_a = 8'd10; seed_b = 8'd15; num = CW'(8); start_i = 1'b1;
    @(posedge clk); #2;
    start_i = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("t6_vec3_a", a_w[0], 13);
    aresetn = 1'b0;
    #1;
    zero_chk("abort");
    @(posedge clk); #2;
    aresetn = 1'b1;
    saw = 0;
    repeat (30) begin
      @(posedge clk); #2;
      if (done_w[0] || done_w[1]) saw = 1;
    end
    chk("t6_no_done", saw, 0);
    run(8'd10, 8'd15, 8, 1'b0, c1, c3);
    chk("t6_cyc1", c1, 9);
    chk("t6_pass", pass_w[0], 1);
    chk("t6_err", err_w[0], 0);

    mode = 3;
    run(8'd10, 8'd15, 8, 1'b0, c1, c3);
    chk("t7_s3_pass", pass_w[1], 1);
    chk("t7_s3_err", err_w[1], 0);
    chk("t7_s1_err_nonzero", err_w[0] != 0, 1);
    chk("t7_s1_pass", pass_w[0], 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
